// File: rtl/multiword_add_sequencer_if.sv
// multiword_add_sequencer_if: start/done request bus between a master and the wide add/sub sequencer.
interface multiword_add_sequencer_if #(parameter int WORDS = 4);
    logic               start;
    logic               sub;
    logic [8*WORDS-1:0] a;
    logic [8*WORDS-1:0] b;
    logic               busy;
    logic               done;
    logic [8*WORDS-1:0] result;
    logic               cout;
    logic               overflow;
    modport master (output start, sub, a, b, input busy, done, result, cout, overflow);
    modport slave  (input start, sub, a, b, output busy, done, result, cout, overflow);
endinterface

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: wide add/sub computed one byte per clock on a shared 8-bit ripple-carry adder.
module ripple_carry_adder #(parameter int W = 8) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;
    assign c[0] = cin;
    assign cout = c[W];
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
endmodule

module multiword_add_sequencer #(parameter int WORDS = 4) (
    input  logic                        clk,
    input  logic                        rst_n,
    multiword_add_sequencer_if.slave    bus
);
    localparam int IW = $clog2(WORDS);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state;
    logic [8*WORDS-1:0] a_r;
    logic [8*WORDS-1:0] b_r;
    logic               sub_r;
    logic [IW-1:0]      idx;
    logic               carry;
    logic               busy;
    logic               done;
    logic [8*WORDS-1:0] result;
    logic               cout;
    logic               overflow;
    logic [7:0]         a_byte;
    logic [7:0]         b_byte;
    logic [7:0]         sum;
    logic               co;
    logic               last;
    // Subtraction is A + ~B + 1: the invert happens here, the +1 is the initial carry.
    assign a_byte = a_r[8*idx +: 8];
    assign b_byte = b_r[8*idx +: 8] ^ {8{sub_r}};
    assign last   = idx == IW'(WORDS - 1);
    ripple_carry_adder #(.W(8)) u_add (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry),
        .sum  (sum),
        .cout (co)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            sub_r    <= 1'b0;
            idx      <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_r   <= bus.a;
                    b_r   <= bus.b;
                    sub_r <= bus.sub;
                    idx   <= '0;
                    carry <= bus.sub;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    result[8*idx +: 8] <= sum;
                    carry <= co;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        cout     <= co;
                        overflow <= (a_byte[7] == b_byte[7]) && (sum[7] != a_byte[7]);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.result   = result;
    assign bus.cout     = cout;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer: randomized and directed checks of the sequencer against an arithmetic model.
module tb_multiword_add_sequencer;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ntot = 0;
    int   npass = 0;
    int   p = 0;
    logic [31:0] er = '0;
    logic        ec = 1'b0;
    logic        eo = 1'b0;
    multiword_add_sequencer_if #(.WORDS(W)) bus ();
    multiword_add_sequencer #(.WORDS(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: plain wide arithmetic plus a cycle count since acceptance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p  <= 0;
            er <= '0;
            ec <= 1'b0;
            eo <= 1'b0;
        end else if (p == 0) begin
            if (bus.start) begin
                longint sa, sb, t;
                sa = longint'($signed(bus.a));
                sb = longint'($signed(bus.b));
                t  = bus.sub ? sa - sb : sa + sb;
                p  <= 1;
                er <= bus.sub ? bus.a - bus.b : bus.a + bus.b;
                ec <= bus.sub ? (bus.a >= bus.b) : ({1'b0, bus.a} + {1'b0, bus.b} > 33'hFFFF_FFFF);
                eo <= (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
        end else if (p == W + 1) p <= 0;
        else p <= p + 1;
    end

    always @(negedge clk) begin
        chk("busy", bus.busy, p >= 1 && p <= W);
        chk("done", bus.done, p == W + 1);
        if (p == 0 || p == W + 1) begin
            chk("result", bus.result, er);
            chk("cout", bus.cout, ec);
            chk("overflow", bus.overflow, eo);
        end
    end

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s, input bit hold,
                          input logic [31:0] lr, input logic lc, input logic lo);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.a = x; bus.b = y; bus.sub = s;
        @(negedge clk);
        if (hold) begin bus.a = '0; bus.b = '0; end
        else bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 20) begin @(negedge clk); n++; end
        bus.start = 1'b0;
        chk("latency", n, 5);
        chk("lit_result", bus.result, lr);
        chk("lit_cout", bus.cout, lc);
        chk("lit_overflow", bus.overflow, lo);
        chk("model_result", er, lr);
        chk("model_flags", {ec, eo}, {lc, lo});
    endtask

    initial begin
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        chk("reset_result", bus.result, 32'h0);
        chk("reset_busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h0000_0000, 1'b1, 1'b0);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h8000_0000, 1'b0, 1'b1);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1, 32'h2345_6789, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        // Reset in the second RUN cycle discards the partial result.
        bus.start = 1'b1; bus.a = 32'h0000_FFFF; bus.b = 32'h0000_0001; bus.sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_result", bus.result, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 0, 32'h0000_0003, 1'b0, 1'b0);
        run_op(32'h00FF_00FF, 32'h0001_0001, 1'b0, 0, 32'h0100_0100, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.sub   = 1'($urandom);
            bus.a     = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            bus.b     = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
